// File: rtl/hub75_row_receiver_if.sv
// Pixel-beat stream from the HUB75 row receiver to its sink.
// The source drives valid/x/y/rgb; the sink drives ready.
interface hub75_row_receiver_if #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned ADDR_BITS = 5
);
  localparam int unsigned X_BITS = $clog2(WIDTH);
  localparam int unsigned Y_BITS = ADDR_BITS + 1;

  logic              px_valid;
  logic              px_ready;
  logic [X_BITS-1:0] px_x;
  logic [Y_BITS-1:0] px_y;
  logic [2:0]        px_rgb;

  modport master (output px_valid, px_x, px_y, px_rgb, input px_ready);
  modport slave  (input px_valid, px_x, px_y, px_rgb, output px_ready);
endinterface

// File: rtl/hub75_row_receiver.sv
// HUB75 receive end: samples the panel pins, rebuilds each latched row pair
// and replays it as a valid/ready pixel stream (top half, then bottom half).
module hub75_row_receiver #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            hub_rgb0,
  input  logic [2:0]            hub_rgb1,
  input  logic [ADDR_BITS-1:0]  hub_addr,
  input  logic                  hub_blank,
  input  logic                  hub_latch,
  input  logic                  hub_sclk,
  hub75_row_receiver_if.master  px,
  output logic                  row_done,
  output logic                  err_count,
  output logic                  err_overrun
);
  localparam int unsigned X_BITS    = $clog2(WIDTH);
  localparam int unsigned CNT_BITS  = X_BITS + 1;
  localparam int unsigned Y_BITS    = ADDR_BITS + 1;
  localparam int unsigned ADDR_LSB  = 6;
  localparam int unsigned SCLK_BIT  = ADDR_LSB + ADDR_BITS;
  localparam int unsigned LATCH_BIT = SCLK_BIT + 1;
  localparam int unsigned BLANK_BIT = LATCH_BIT + 1;
  localparam int unsigned PIN_BITS  = BLANK_BIT + 1;

  localparam logic [X_BITS-1:0]   X_LAST   = X_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TOP  = 2'd1,
    BOT  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][PIN_BITS-1:0] sync_q;
  logic [PIN_BITS-1:0]  pins;
  logic [PIN_BITS-1:0]  synced;
  logic                 sclk_hist;
  logic                 latch_hist;
  logic                 sclk_rise;
  logic                 latch_rise;
  logic [2:0]           rgb0_d;
  logic [2:0]           rgb1_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic                 unused_blank;

  logic [WIDTH-1:0][2:0] sbuf0;
  logic [WIDTH-1:0][2:0] sbuf1;
  logic [WIDTH-1:0][2:0] hbuf0;
  logic [WIDTH-1:0][2:0] hbuf1;
  logic [CNT_BITS-1:0]   cnt;
  logic                  ovf;
  logic [ADDR_BITS-1:0]  row_addr;

  state_t              state;
  state_t              state_n;
  logic                accept;
  logic                valid_n;
  logic                done_n;
  logic [X_BITS-1:0]   x_n;
  logic [Y_BITS-1:0]   y_n;
  logic [2:0]          rgb_n;

  assign pins         = {hub_blank, hub_latch, hub_sclk, hub_addr, hub_rgb1, hub_rgb0};
  assign synced       = sync_q[SYNC_STAGES-1];
  assign unused_blank = synced[BLANK_BIT];
  assign accept       = px.px_valid && px.px_ready;

  // Synchroniser chain, edge history, and strobe-aligned data capture.
  // Data is registered alongside the edge pulse so both arrive together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      sclk_hist  <= 1'b0;
      latch_hist <= 1'b0;
      sclk_rise  <= 1'b0;
      latch_rise <= 1'b0;
      rgb0_d     <= '0;
      rgb1_d     <= '0;
      addr_d     <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sclk_hist  <= synced[SCLK_BIT];
      latch_hist <= synced[LATCH_BIT];
      sclk_rise  <= synced[SCLK_BIT] & ~sclk_hist;
      latch_rise <= synced[LATCH_BIT] & ~latch_hist;
      rgb0_d     <= synced[2:0];
      rgb1_d     <= synced[5:3];
      addr_d     <= synced[ADDR_LSB +: ADDR_BITS];
    end
  end

  // Shift buffer fill, latch handoff to the hold buffer, and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sbuf0       <= '0;
      sbuf1       <= '0;
      hbuf0       <= '0;
      hbuf1       <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      row_addr    <= '0;
      err_count   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_count   <= 1'b0;
      err_overrun <= 1'b0;
      if (latch_rise) begin
        err_count <= (cnt != CNT_FULL) || ovf;
        cnt       <= '0;
        ovf       <= 1'b0;
        sbuf0     <= '0;
        sbuf1     <= '0;
        if (state == IDLE) begin
          hbuf0    <= sbuf0;
          hbuf1    <= sbuf1;
          row_addr <= addr_d;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (sclk_rise) begin
        if (cnt != CNT_FULL) begin
          sbuf0[cnt[X_BITS-1:0]] <= rgb0_d;
          sbuf1[cnt[X_BITS-1:0]] <= rgb1_d;
          cnt                    <= cnt + CNT_BITS'(1);
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Drain FSM state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      px.px_valid <= 1'b0;
      px.px_x     <= '0;
      px.px_y     <= '0;
      px.px_rgb   <= '0;
      row_done    <= 1'b0;
    end else begin
      state       <= state_n;
      px.px_valid <= valid_n;
      px.px_x     <= x_n;
      px.px_y     <= y_n;
      px.px_rgb   <= rgb_n;
      row_done    <= done_n;
    end
  end

  // Next state and next output values. TOP enters with valid low, giving a
  // one-cycle gap in which the freshly loaded hold buffer settles.
  always_comb begin
    state_n = state;
    valid_n = px.px_valid;
    x_n     = px.px_x;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (latch_rise) begin
          state_n = TOP;
          valid_n = 1'b0;
          x_n     = '0;
        end
      end
      TOP: begin
        if (!px.px_valid) begin
          valid_n = 1'b1;
          x_n     = '0;
        end else if (accept) begin
          x_n = px.px_x + X_BITS'(1);
          if (px.px_x == X_LAST) begin
            state_n = BOT;
          end
        end
      end
      BOT: begin
        if (accept) begin
          x_n = px.px_x + X_BITS'(1);
          if (px.px_x == X_LAST) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
    y_n   = {state_n == BOT, row_addr};
    rgb_n = (state_n == BOT) ? hbuf1[x_n] : hbuf0[x_n];
  end
endmodule

// File: tb/tb_hub75_row_receiver.sv
// Directed plus randomized bench for hub75_row_receiver against a queue-based
// model of which pixels each latched row pair should replay.
module tb_hub75_row_receiver;
  localparam int WIDTH       = 64;
  localparam int ADDR_BITS   = 5;
  localparam int SYNC_STAGES = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [2:0]           hub_rgb0;
  logic [2:0]           hub_rgb1;
  logic [ADDR_BITS-1:0] hub_addr;
  logic                 hub_blank;
  logic                 hub_latch;
  logic                 hub_sclk;
  logic                 row_done;
  logic                 err_count;
  logic                 err_overrun;

  hub75_row_receiver_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) px_if ();

  hub75_row_receiver #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset),
    .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1), .hub_addr(hub_addr),
    .hub_blank(hub_blank), .hub_latch(hub_latch), .hub_sclk(hub_sclk),
    .px(px_if),
    .row_done(row_done), .err_count(err_count), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0 low, 1 high, 2 pattern 1,0,0,1, 3 random
  int n_done, n_errc, n_ovr, last_done_cyc, first_valid_cyc, latch_cyc;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_out = '0;
  logic [14:0] beats[$];
  int          beat_cyc[$];
  logic [14:0] exp_beats[$];
  int          m0[$];
  int          m1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive ready, sample outputs on the falling edge, log beats/pulses.
  task automatic step();
    logic        r;
    logic [14:0] cur;
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      0:       r = 1'b0;
      1:       r = 1'b1;
      2:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: r = 1'($urandom_range(0, 1));
    endcase
    px_if.px_ready = r;
    cur = {px_if.px_x, px_if.px_y, px_if.px_rgb};
    if (prev_stall) begin
      check("stall_valid", 32'(px_if.px_valid), 1);
      check("stall_hold", 32'(cur), 32'(prev_out));
    end
    if (px_if.px_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (px_if.px_valid === 1'b1 && r) begin
      beats.push_back(cur);
      beat_cyc.push_back(cyc);
    end
    prev_stall = (px_if.px_valid === 1'b1) && !r;
    prev_out   = cur;
    if (row_done === 1'b1) begin n_done++; last_done_cyc = cyc; end
    if (err_count === 1'b1) n_errc++;
    if (err_overrun === 1'b1) n_ovr++;
  endtask

  task automatic begin_test();
    beats.delete();
    beat_cyc.delete();
    n_done = 0; n_errc = 0; n_ovr = 0;
    last_done_cyc = -1; first_valid_cyc = -1;
    m0.delete(); m1.delete();
  endtask

  task automatic shift_px(input logic [2:0] a, input logic [2:0] b);
    hub_rgb0 = a; hub_rgb1 = b; hub_blank = 1'($urandom_range(0, 1));
    hub_sclk = 1'b0; step(); step();
    hub_sclk = 1'b1; step(); step();
  endtask

  task automatic latch_row();
    hub_sclk = 1'b0; step(); step();
    hub_latch = 1'b1; latch_cyc = cyc; step(); step();
    hub_latch = 1'b0; step(); step();
  endtask

  task automatic send_row(input int addr);
    hub_addr = ADDR_BITS'(addr);
    for (int i = 0; i < m0.size(); i++) shift_px(3'(m0[i]), 3'(m1[i]));
    latch_row();
  endtask

  // Model: pixel x of each half is the x-th value shifted, or 0 if never shifted.
  task automatic expect_row(input int addr);
    int v;
    exp_beats.delete();
    for (int h = 0; h < 2; h++) begin
      for (int x = 0; x < WIDTH; x++) begin
        if (h == 0) v = (x < m0.size()) ? m0[x] : 0;
        else        v = (x < m1.size()) ? m1[x] : 0;
        exp_beats.push_back({6'(x), 6'(h * (1 << ADDR_BITS) + addr), 3'(v)});
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (beats.size() < exp_beats.size() && n < budget) begin step(); n++; end
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic compare_row(input string tag, input int errc, input int ovr);
    check({tag, "_nbeats"}, beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp_beats[i]));
      if (beats[i] !== exp_beats[i]) break;
    end
    check({tag, "_row_done"}, n_done, 1);
    if (beat_cyc.size() > 0)
      check({tag, "_done_at"}, last_done_cyc, beat_cyc[beat_cyc.size()-1] + 1);
    check({tag, "_err_count"}, n_errc, errc);
    check({tag, "_err_overrun"}, n_ovr, ovr);
    check({tag, "_idle_valid"}, 32'(px_if.px_valid), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; hub_rgb0 = '0; hub_rgb1 = '0; hub_addr = '0;
    hub_blank = 1'b0; hub_latch = 1'b0; hub_sclk = 1'b0; px_if.px_ready = 1'b0;
    begin_test();
    step(); step(); step();
    check("rst_valid", 32'(px_if.px_valid), 0);
    check("rst_x", 32'(px_if.px_x), 0);
    check("rst_y", 32'(px_if.px_y), 0);
    check("rst_rgb", 32'(px_if.px_rgb), 0);
    check("rst_pulses", 32'({row_done, err_count, err_overrun}), 0);
    reset = 1'b0;
    step();

    // Nominal row, ready held high: latency, throughput and spot beats.
    begin_test(); rdy_mode = 1;
    for (int x = 0; x < WIDTH; x++) begin m0.push_back(x % 8); m1.push_back(7 - (x % 8)); end
    expect_row(5);
    send_row(5);
    drain(1000);
    compare_row("nominal", 0, 0);
    check("latency", first_valid_cyc - latch_cyc, SYNC_STAGES + 3);
    if (beats.size() == 2 * WIDTH) begin
      check("throughput", beat_cyc[2*WIDTH-1] - beat_cyc[0], 2 * WIDTH - 1);
      check("beat0", 32'(beats[0]), 32'({6'd0, 6'd5, 3'd0}));
      check("beat63", 32'(beats[63]), 32'({6'd63, 6'd5, 3'd7}));
      check("beat64", 32'(beats[64]), 32'({6'd0, 6'd37, 3'd7}));
      check("beat127", 32'(beats[127]), 32'({6'd63, 6'd37, 3'd0}));
    end

    // Backpressure with ready 1,0,0,1.
    begin_test(); rdy_mode = 2;
    for (int x = 0; x < WIDTH; x++) begin m0.push_back(x % 8); m1.push_back(7 - (x % 8)); end
    expect_row(5);
    send_row(5);
    drain(2000);
    compare_row("backpressure", 0, 0);

    // Short row: 63 pulses of 7; column 63 reads back 0.
    begin_test(); rdy_mode = 3;
    for (int x = 0; x < WIDTH - 1; x++) begin m0.push_back(7); m1.push_back(7); end
    n = int'($urandom_range(0, 31));
    expect_row(n);
    send_row(n);
    drain(2000);
    compare_row("short", 1, 0);

    // Long row: 70 pulses, extra pulses ignored.
    begin_test(); rdy_mode = 3;
    for (int x = 0; x < WIDTH + 6; x++) begin
      m0.push_back(x < WIDTH ? 1 : 6);
      m1.push_back(int'($urandom_range(0, 7)));
    end
    n = int'($urandom_range(0, 31));
    expect_row(n);
    send_row(n);
    drain(2000);
    compare_row("long", 1, 0);

    // Overrun: row A stalled, row B latched during the drain and discarded.
    begin_test(); rdy_mode = 0;
    for (int x = 0; x < WIDTH; x++) begin
      m0.push_back(int'($urandom_range(0, 7))); m1.push_back(int'($urandom_range(0, 7)));
    end
    expect_row(2);
    send_row(2);
    m0.delete(); m1.delete();
    for (int x = 0; x < WIDTH; x++) begin
      m0.push_back(int'($urandom_range(0, 7))); m1.push_back(int'($urandom_range(0, 7)));
    end
    send_row(9);
    check("ovr_pulse_before_drain", n_ovr, 1);
    check("ovr_no_beats_stalled", beats.size(), 0);
    rdy_mode = 1;
    drain(1000);
    for (int i = 0; i < 20; i++) step();
    compare_row("overrun", 0, 1);

    // Reset mid-drain after 10 accepted beats.
    begin_test(); rdy_mode = 0;
    for (int x = 0; x < WIDTH; x++) begin
      m0.push_back(int'($urandom_range(0, 7))); m1.push_back(int'($urandom_range(0, 7)));
    end
    send_row(int'($urandom_range(0, 31)));
    rdy_mode = 1;
    n = 0;
    while (beats.size() < 10 && n < 200) begin step(); n++; end
    rdy_mode = 0;
    step();
    reset = 1'b1; prev_stall = 1'b0;
    step();
    check("rstmid_valid", 32'(px_if.px_valid), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("rstmid_beats", beats.size(), 10);
    check("rstmid_no_done", n_done, 0);
    check("rstmid_valid_later", 32'(px_if.px_valid), 0);
    begin_test(); rdy_mode = 3;
    for (int x = 0; x < WIDTH; x++) begin
      m0.push_back(int'($urandom_range(0, 7))); m1.push_back(int'($urandom_range(0, 7)));
    end
    n = int'($urandom_range(0, 31));
    expect_row(n);
    send_row(n);
    drain(2000);
    compare_row("after_reset", 0, 0);

    // Random rows of random length around WIDTH.
    for (int r = 0; r < 3; r++) begin
      int len;
      begin_test(); rdy_mode = 3;
      len = WIDTH - 2 + int'($urandom_range(0, 4));
      for (int x = 0; x < len; x++) begin
        m0.push_back(int'($urandom_range(0, 7))); m1.push_back(int'($urandom_range(0, 7)));
      end
      n = int'($urandom_range(0, 31));
      expect_row(n);
      send_row(n);
      drain(2000);
      compare_row($sformatf("rand%0d", r), (len != WIDTH) ? 1 : 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hub75_row_receiver.md
Name: hub75_row_receiver

Overview:
- Receive end of the HUB75 LED-panel link. The block samples the panel pins driven by our panel scanner: rgb0, rgb1, addr, blank, latch and sclk.
- It reconstructs each latched row pair and replays it as a pixel stream with a valid/ready handshake.
- Uses: loopback self-test of the panel driver on a second PMOD, and a panel-emulator front end feeding a framebuffer writer.
- All hub_* inputs are asynchronous pins; the block synchronises them internally.

Parameters:
- WIDTH, 64: pixels per row (sclk pulses per row); power of two.
- ADDR_BITS, 5: row-address width; a panel has 2^(ADDR_BITS+1) rows.
- SYNC_STAGES, 2: flip-flop stages on each hub_* input.

Ports:
- clk  in  1  receiver clock. Must be at least 4x the panel sclk rate; sclk high and low each last at least 2 clk periods.
- reset  in  1  synchronous, active-high reset.
- hub_rgb0  in  3  top-half {R,G,B} data bit.
- hub_rgb1  in  3  bottom-half {R,G,B} data bit.
- hub_addr  in  ADDR_BITS  row address.
- hub_blank  in  1  panel blank; ignored except for synchronisation.
- hub_latch  in  1  row latch strobe.
- hub_sclk  in  1  shift clock.
- px_valid  out  1  pixel beat valid.
- px_ready  in  1  sink accepts the beat.
- px_x  out  log2(WIDTH)  column.
- px_y  out  ADDR_BITS+1  row; the MSB selects the bottom half.
- px_rgb  out  3  {R,G,B}.
- row_done  out  1  one-cycle pulse after a row pair has fully drained.
- err_count  out  1  one-cycle pulse: the latched row did not have exactly WIDTH sclk edges.
- err_overrun  out  1  one-cycle pulse: a latch arrived while a drain was still in progress.

Behaviour:
- Reset (synchronous, active-high) clears all of the following to 0:
  - synchroniser and edge-detect registers;
  - shift and hold buffers;
  - shift count and overflow flag;
  - the FSM (goes to IDLE);
  - px_valid, px_x, px_y, px_rgb, row_done, err_count, err_overrun.
- Reset mid-drain aborts the drain; no further beats or pulses are emitted.
- Synchronisation: every hub_* input passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - The rgb and addr paths are delayed identically to sclk and latch, so data is sampled at the same point as its strobe.
- Shift path, on each detected sclk rising edge:
  - If cnt < WIDTH: sbuf0[cnt] <= rgb0 and sbuf1[cnt] <= rgb1, then cnt++. The first pixel shifted in is x=0.
  - If cnt == WIDTH: the edge is ignored and the sticky ovf flag is set.
- Latch rising edge, all in the same clk cycle:
  - err_count pulses if cnt != WIDTH or ovf is set.
  - cnt <= 0 and ovf <= 0.
  - If the FSM is IDLE: hbuf <= sbuf, row_addr <= synced addr, and the FSM goes to TOP.
  - Otherwise: err_overrun pulses, the new row is discarded, and the drain continues unchanged.
  - In both cases sbuf is cleared to 0, so columns that were never shifted read back as 0.
- A latch edge and an sclk edge in the same cycle: the latch takes priority and the sclk edge is dropped.
- FSM, with states IDLE, TOP and BOT:
  - TOP emits beats x = 0..WIDTH-1 with y = {0,row_addr} and rgb = hbuf0[x].
  - BOT emits beats x = 0..WIDTH-1 with y = {1,row_addr} and rgb = hbuf1[x].
  - TOP → BOT on acceptance of the x = WIDTH-1 beat; BOT → IDLE on acceptance of its x = WIDTH-1 beat.
  - row_done pulses in the cycle after the final BOT beat is accepted.
  - A latch edge detected in that same cycle is treated as IDLE, so no overrun is flagged.
- Handshake:
  - A beat is accepted on a clk edge where px_valid && px_ready.
  - px_x, px_y and px_rgb are registered and held stable while px_valid && !px_ready.
  - px_valid never drops without acceptance, except on reset.
  - Maximum throughput is 1 beat per clk, so 2*WIDTH beats take exactly 2*WIDTH clk with px_ready held high.
- Latency: px_valid rises exactly SYNC_STAGES+2 clk after the first clk edge that samples hub_latch high.
- Wrap-around:
  - px_x wraps naturally at WIDTH-1.
  - No frame counting; each row pair is independent.
  - An sclk edge after the latch starts the next row at x=0.

Test Plan:
- Nominal row, with addr=5, rgb0 = x[2:0] and rgb1 = ~x[2:0], 64 sclk pulses, then latch, px_ready=1:
  - 128 consecutive beats.
  - Beat 0: x=0, y=5, rgb=0. Beat 63: x=63, y=5, rgb=7.
  - Beat 64: x=0, y=37, rgb=7. Beat 127: x=63, y=37, rgb=0.
  - row_done pulses once; no error pulses.
- Backpressure: same row with px_ready toggling 1,0,0,1 repeating:
  - the same 128-beat sequence;
  - outputs stable through every stall;
  - no beat duplicated or skipped.
- Short row: 63 sclk pulses with rgb0=rgb1=7, then latch → err_count pulses once; x=63 beats carry rgb=0 in both halves, all other beats carry 7.
- Long row: 70 sclk pulses, with rgb0=1 for the first 64 and 6 afterwards, then latch → err_count pulses once; all top-half beats carry rgb=1.
- Overrun: row A (addr=2) latched with px_ready=0, then row B (addr=9) fully shifted and latched:
  - err_overrun pulses once;
  - after px_ready is raised, 128 beats all carry y=2 or y=34;
  - no beats appear for row B.
- Reset mid-drain: assert reset for 1 clk after 10 accepted beats:
  - px_valid is 0 on the next cycle, with no row_done;
  - a fresh nominal row then drains correctly starting at x=0.
